// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared channel state type and default sizing for the timer bank
package timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_t;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W  = 32;

endpackage

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one down-counting timer channel, one-shot or auto-reload
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic [CNT_W-1:0] duration,
  input  logic             ack,
  output logic             busy,
  output logic             done,
  output logic             pending,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  ch_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             done_q, pend_q, pend_d;
  logic             expire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      done_q   <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      done_q   <= expire;
      pend_q   <= pend_d;
    end
  end

  // Priority: stop, then start/restart, then the running count.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    expire   = 1'b0;
    if (stop) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (start) begin
      reload_d = duration;
      mode_d   = periodic;
      if (duration == '0) begin
        state_d = IDLE;
        cnt_d   = '0;
        expire  = 1'b1;
      end else begin
        state_d = RUN;
        cnt_d   = duration;
      end
    end else if (state_q == RUN) begin
      if (cnt_q > ONE) begin
        cnt_d = cnt_q - ONE;
      end else if (cnt_q == ONE) begin
        expire = 1'b1;
        if (mode_q) begin
          cnt_d = reload_q;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end else begin
        state_d = IDLE;
      end
    end
    pend_d = expire | (pend_q & ~ack);
  end

  assign busy    = (state_q == RUN);
  assign done    = done_q;
  assign pending = pend_q;
  assign count   = cnt_q;

endmodule

// File: rtl/timer_bank.sv
// rtl/timer_bank.sv - bank of independent timer channels with a shared interrupt
module timer_bank
  import timer_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       stop,
  input  logic [NUM_CH-1:0]       periodic,
  input  logic [NUM_CH*CNT_W-1:0] duration,
  input  logic [NUM_CH-1:0]       ack,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done,
  output logic [NUM_CH-1:0]       pending,
  output logic [NUM_CH*CNT_W-1:0] count,
  output logic                    irq
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    timer_channel #(.CNT_W(CNT_W)) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start[i]),
      .stop     (stop[i]),
      .periodic (periodic[i]),
      .duration (duration[i*CNT_W +: CNT_W]),
      .ack      (ack[i]),
      .busy     (busy[i]),
      .done     (done[i]),
      .pending  (pending[i]),
      .count    (count[i*CNT_W +: CNT_W])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq <= 1'b0;
    else        irq <= |pending;
  end

endmodule
